// File: rtl/arb_mux_rr_if.sv
// Handshake bundle for arb_mux_rr: N request channels in, one registered output port.
// The slave modport is the arbiter's view; master is the environment driving it.
interface arb_mux_rr_if #(
    parameter int WIDTH = 32,
    parameter int N     = 4
);
    localparam int SELW = $clog2(N);

    logic [N*WIDTH-1:0] data_i;
    logic [N-1:0]       valid_i;
    logic [N-1:0]       ready_o;
    logic               mode_i;
    logic [SELW-1:0]    select_i;
    logic [WIDTH-1:0]   data_o;
    logic               valid_o;
    logic               ready_i;
    logic [SELW-1:0]    grant_o;

    modport slave (
        input  data_i, valid_i, mode_i, select_i, ready_i,
        output ready_o, data_o, valid_o, grant_o
    );

    modport master (
        output data_i, valid_i, mode_i, select_i, ready_i,
        input  ready_o, data_o, valid_o, grant_o
    );
endinterface

// File: rtl/arb_mux_rr.sv
// N-channel arbitrating mux (round-robin or forced select) with a one-entry output register.
// Optional per-channel saturating accept counters: define ARB_MUX_RR_COUNT_EN.
module arb_mux_rr #(
    parameter int WIDTH = 32,
    parameter int N     = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    arb_mux_rr_if.slave      bus
`ifdef ARB_MUX_RR_COUNT_EN
    ,
    output logic [N*16-1:0]  count_o
`endif
);
    localparam int SELW = $clog2(N);

    logic [WIDTH-1:0] data_q, data_d;
    logic [SELW-1:0]  grant_q, grant_d;
    logic             valid_q, valid_d;
    logic [SELW-1:0]  ptr_q, ptr_d;

    logic             load_en;
    logic             rr_found;
    logic [SELW-1:0]  rr_idx;
    logic             sel_ok;
    logic             found;
    logic [SELW-1:0]  choice;
    logic             accept;

    assign load_en = !valid_q || bus.ready_i;

    // Cyclic scan starting at the pointer; first valid requester wins.
    always_comb begin
        int k;
        rr_found = 1'b0;
        rr_idx   = '0;
        k        = 0;
        for (int i = 0; i < N; i++) begin
            k = (int'(ptr_q) + i) % N;
            if (!rr_found && bus.valid_i[k]) begin
                rr_found = 1'b1;
                rr_idx   = SELW'(k);
            end
        end
    end

    // Out-of-range select (non power-of-two N) never matches a channel.
    always_comb begin
        sel_ok = 1'b0;
        if (32'(bus.select_i) < N)
            sel_ok = bus.valid_i[bus.select_i];
    end

    assign found  = bus.mode_i ? sel_ok : rr_found;
    assign choice = bus.mode_i ? bus.select_i : rr_idx;
    assign accept = !rst_i && load_en && found;

    always_comb begin
        bus.ready_o = '0;
        if (accept)
            bus.ready_o[choice] = 1'b1;
    end

    always_comb begin
        data_d  = data_q;
        grant_d = grant_q;
        valid_d = valid_q;
        ptr_d   = ptr_q;
        if (accept) begin
            data_d  = bus.data_i[choice*WIDTH +: WIDTH];
            grant_d = choice;
            valid_d = 1'b1;
            if (!bus.mode_i)
                ptr_d = (32'(choice) == N - 1) ? '0 : choice + 1'b1;
        end else if (bus.ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_q  <= '0;
            grant_q <= '0;
            valid_q <= 1'b0;
            ptr_q   <= '0;
        end else begin
            data_q  <= data_d;
            grant_q <= grant_d;
            valid_q <= valid_d;
            ptr_q   <= ptr_d;
        end
    end

    assign bus.data_o  = data_q;
    assign bus.grant_o = grant_q;
    assign bus.valid_o = valid_q;

`ifdef ARB_MUX_RR_COUNT_EN
    logic [N-1:0][15:0] cnt_q;

    for (genvar g = 0; g < N; g++) begin : g_cnt
        logic [15:0] cnt_d;
        always_comb begin
            cnt_d = cnt_q[g];
            if (accept && choice == SELW'(g) && cnt_q[g] != 16'hFFFF)
                cnt_d = cnt_q[g] + 16'd1;
        end
        always_ff @(posedge clk_i) begin
            if (rst_i) cnt_q[g] <= '0;
            else       cnt_q[g] <= cnt_d;
        end
    end

    assign count_o = cnt_q;
`endif
endmodule

// File: tb/tb_arb_mux_rr.sv
// Directed self-checking bench for arb_mux_rr (N=4, WIDTH=32).
module tb_arb_mux_rr;
    localparam int WIDTH = 32;
    localparam int N     = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    arb_mux_rr_if #(.WIDTH(WIDTH), .N(N)) bus ();

`ifdef ARB_MUX_RR_COUNT_EN
    logic [N*16-1:0] count;
    arb_mux_rr #(.WIDTH(WIDTH), .N(N)) dut (.clk_i(clk), .rst_i(rst), .bus(bus), .count_o(count));
`else
    arb_mux_rr #(.WIDTH(WIDTH), .N(N)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));
`endif

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data();
        for (int k = 0; k < N; k++)
            bus.data_i[k*WIDTH +: WIDTH] = 32'h1000 + 32'(k);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.valid_i = 4'b1111;
        bus.mode_i = 1'b0;
        bus.select_i = '0;
        bus.ready_i = 1'b1;
        step();
        step();
        checks++;
        if (bus.valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", bus.valid_o); end
        checks++;
        if (bus.data_o !== 32'h0) begin failures++; $display("FAIL reset_data got=%h exp=0", bus.data_o); end
        checks++;
        if (bus.grant_o !== 2'd0) begin failures++; $display("FAIL reset_grant got=%0d exp=0", bus.grant_o); end
        checks++;
        if (bus.ready_o !== 4'b0000) begin failures++; $display("FAIL reset_ready got=%b exp=0000", bus.ready_o); end
        rst = 1'b0;
        #1;
        checks++;
        if (bus.ready_o !== 4'b0001) begin failures++; $display("FAIL post_reset_ready got=%b exp=0001", bus.ready_o); end
        step();
        checks++;
        if (bus.grant_o !== 2'd0 || bus.valid_o !== 1'b1 || bus.data_o !== 32'h1000) begin
            failures++;
            $display("FAIL post_reset_first grant=%0d valid=%b data=%h exp 0/1/1000", bus.grant_o, bus.valid_o, bus.data_o);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_seq [5];
        exp_seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        do_reset();
        bus.mode_i = 1'b0;
        bus.valid_i = 4'b1111;
        bus.ready_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (bus.ready_o !== (4'b0001 << exp_seq[i])) begin
                failures++;
                $display("FAIL rr_ready[%0d] got=%b exp=%b", i, bus.ready_o, 4'b0001 << exp_seq[i]);
            end
            step();
            checks++;
            if (bus.data_o !== 32'h1000 + 32'(exp_seq[i]) || bus.grant_o !== exp_seq[i] || bus.valid_o !== 1'b1) begin
                failures++;
                $display("FAIL rr_out[%0d] data=%h grant=%0d valid=%b exp data=%h grant=%0d",
                         i, bus.data_o, bus.grant_o, bus.valid_o, 32'h1000 + 32'(exp_seq[i]), exp_seq[i]);
            end
        end
    endtask

    task automatic test_sparse_wrap();
        logic [1:0] exp_seq [3];
        exp_seq = '{2'd0, 2'd2, 2'd0};
        do_reset();
        bus.mode_i = 1'b0;
        bus.valid_i = 4'b1111;
        bus.ready_i = 1'b1;
        step(); step(); step();   // grants 0,1,2 leave ptr at 3
        bus.valid_i = 4'b0101;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (bus.grant_o !== exp_seq[i] || bus.data_o !== 32'h1000 + 32'(exp_seq[i])) begin
                failures++;
                $display("FAIL sparse[%0d] grant=%0d data=%h exp grant=%0d", i, bus.grant_o, bus.data_o, exp_seq[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        // Continues from sparse: output holds ch0 (1000), ptr=1
        bus.ready_i = 1'b0;
        bus.valid_i = 4'b0010;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (bus.ready_o !== 4'b0000) begin failures++; $display("FAIL bp_ready[%0d] got=%b exp=0000", i, bus.ready_o); end
            step();
            checks++;
            if (bus.data_o !== 32'h1000 || bus.grant_o !== 2'd0 || bus.valid_o !== 1'b1) begin
                failures++;
                $display("FAIL bp_hold[%0d] data=%h grant=%0d valid=%b exp 1000/0/1", i, bus.data_o, bus.grant_o, bus.valid_o);
            end
        end
        bus.ready_i = 1'b1;
        #1;
        checks++;
        if (bus.ready_o !== 4'b0010) begin failures++; $display("FAIL bp_release_ready got=%b exp=0010", bus.ready_o); end
        step();
        checks++;
        if (bus.data_o !== 32'h1001 || bus.grant_o !== 2'd1 || bus.valid_o !== 1'b1) begin
            failures++;
            $display("FAIL bp_refill data=%h grant=%0d valid=%b exp 1001/1/1", bus.data_o, bus.grant_o, bus.valid_o);
        end
    endtask

    task automatic test_forced();
        // ptr=2 on entry; forced accepts of ch2 must not move it
        bus.mode_i = 1'b1;
        bus.select_i = 2'd2;
        bus.valid_i = 4'b1111;
        bus.ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (bus.ready_o !== 4'b0100) begin failures++; $display("FAIL forced_ready[%0d] got=%b exp=0100", i, bus.ready_o); end
            step();
            checks++;
            if (bus.data_o !== 32'h1002 || bus.grant_o !== 2'd2) begin
                failures++;
                $display("FAIL forced_out[%0d] data=%h grant=%0d exp 1002/2", i, bus.data_o, bus.grant_o);
            end
        end
        bus.valid_i = 4'b1011;
        #1;
        checks++;
        if (bus.ready_o !== 4'b0000) begin failures++; $display("FAIL forced_idle_ready got=%b exp=0000", bus.ready_o); end
        step();
        checks++;
        if (bus.valid_o !== 1'b0 || bus.data_o !== 32'h1002 || bus.grant_o !== 2'd2) begin
            failures++;
            $display("FAIL forced_drain valid=%b data=%h grant=%0d exp 0/1002/2", bus.valid_o, bus.data_o, bus.grant_o);
        end
        bus.mode_i = 1'b0;
        bus.valid_i = 4'b1111;
        #1;
        checks++;
        if (bus.ready_o !== 4'b0100) begin failures++; $display("FAIL forced_ptr_kept got=%b exp=0100", bus.ready_o); end
        step();
        checks++;
        if (bus.grant_o !== 2'd2 || bus.valid_o !== 1'b1) begin
            failures++;
            $display("FAIL forced_ptr_grant grant=%0d valid=%b exp 2/1", bus.grant_o, bus.valid_o);
        end
    endtask

`ifdef ARB_MUX_RR_COUNT_EN
    task automatic test_count();
        do_reset();
        bus.mode_i = 1'b0;
        bus.valid_i = 4'b0001;
        bus.ready_i = 1'b1;
        for (int i = 0; i < 5; i++) step();
        checks++;
        if (count !== 64'h0000_0000_0000_0005) begin failures++; $display("FAIL count_small got=%h exp=5 on ch0", count); end
        for (int i = 0; i < 69995; i++) step();
        checks++;
        if (count !== 64'h0000_0000_0000_FFFF) begin failures++; $display("FAIL count_sat got=%h exp=FFFF on ch0", count); end
        bus.valid_i = 4'b0000;
        do_reset();
        checks++;
        if (count !== 64'h0) begin failures++; $display("FAIL count_clear got=%h exp=0", count); end
    endtask
`endif

    initial begin
        bus.data_i = '0;
        bus.valid_i = '0;
        bus.mode_i = 1'b0;
        bus.select_i = '0;
        bus.ready_i = 1'b0;
        set_data();
        test_reset();
        test_round_robin();
        test_sparse_wrap();
        test_backpressure();
        test_forced();
`ifdef ARB_MUX_RR_COUNT_EN
        test_count();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
